// File: rtl/uart_status_tx_if.sv
// Status-transmitter handshake bundle: send request and status bytes in,
// serial line and packet progress flags out.
interface uart_status_tx_if;
   logic       send;
   logic [7:0] p_hp;
   logic [7:0] mon_hp;
   logic [7:0] m_state;
   logic       tx;
   logic       busy;
   logic       done;

   // Side that requests packets and watches the line.
   modport master (
      output send, p_hp, mon_hp, m_state,
      input  tx, busy, done
   );

   // The transmitter itself.
   modport slave (
      input  send, p_hp, mon_hp, m_state,
      output tx, busy, done
   );
endinterface

// File: rtl/uart_status_tx.sv
// Game-status UART transmitter: on an accepted send it latches player HP,
// monster HP and machine state and streams them to the host as 8N1, LSB
// first, preceded by a fixed header byte. Bytes go back to back with no
// idle gap between one stop bit and the next start bit.
// Build option: define STATUS_CHECKSUM_EN to append an 8-bit additive
// checksum byte (5-byte packet); without it the packet is 4 bytes.
module uart_status_tx #(
   parameter int         CLK_FREQ = 100000000,
   parameter int         BAUD     = 9600,
   parameter logic [7:0] HEADER   = 8'hA5
) (
   input  logic           clk,
   input  logic           reset,
   uart_status_tx_if.slave bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef STATUS_CHECKSUM_EN
   localparam int NUM_BYTES = 5;
`else
   localparam int NUM_BYTES = 4;
`endif
   localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] baudCnt;
   logic [2:0]       bitIdx;
   logic [2:0]       byteIdx;
   logic             txReg;
   logic             busyReg;
   logic             doneReg;

   // Status snapshot; only ever read while a packet is in flight, so it
   // needs no reset.
   logic [7:0] pHpLat;
   logic [7:0] monHpLat;
   logic [7:0] mStateLat;

   logic       accept;
   logic [2:0] nextBit;
   logic [7:0] curByte;

`ifdef STATUS_CHECKSUM_EN
   // Additive checksum over the three status bytes, wrapping at 8 bits.
   function automatic logic [7:0] statusSum(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] c);
      return a + b + c;
   endfunction
`endif

   // A request only starts a packet from a settled IDLE; the cycle that
   // carries the done pulse is deliberately excluded.
   assign accept  = (state == IDLE) && bus.send && !doneReg;
   assign nextBit = bitIdx + 3'd1;

   // Select the byte currently being serialised from the packet index.
   always_comb begin
      curByte = HEADER;
      case (byteIdx)
         3'd1:    curByte = pHpLat;
         3'd2:    curByte = monHpLat;
         3'd3:    curByte = mStateLat;
`ifdef STATUS_CHECKSUM_EN
         3'd4:    curByte = statusSum(pHpLat, monHpLat, mStateLat);
`endif
         default: curByte = HEADER;
      endcase
   end

   // Capture the status inputs on the accepting edge only.
   always_ff @(posedge clk) begin
      if (accept) begin
         pHpLat    <= bus.p_hp;
         monHpLat  <= bus.mon_hp;
         mStateLat <= bus.m_state;
      end
   end

   // Packet FSM; tx/busy/done are registered so the line changes one cycle
   // after each decision, and every state entry restarts the baud count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         baudCnt <= '0;
         bitIdx  <= '0;
         byteIdx <= '0;
         txReg   <= 1'b1;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               txReg <= 1'b1;
               if (accept) begin
                  byteIdx <= '0;
                  baudCnt <= '0;
                  busyReg <= 1'b1;
                  txReg   <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (baudCnt == CNT_LAST) begin
                  baudCnt <= '0;
                  bitIdx  <= '0;
                  txReg   <= curByte[0];
                  state   <= DATA;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            DATA: begin
               if (baudCnt == CNT_LAST) begin
                  baudCnt <= '0;
                  if (bitIdx == 3'd7) begin
                     txReg <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitIdx <= nextBit;
                     txReg  <= curByte[nextBit];
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            STOP: begin
               if (baudCnt == CNT_LAST) begin
                  baudCnt <= '0;
                  if (byteIdx == LAST_BYTE) begin
                     txReg   <= 1'b1;
                     busyReg <= 1'b0;
                     doneReg <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     byteIdx <= byteIdx + 3'd1;
                     txReg   <= 1'b0;
                     state   <= START;
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            default: begin
               txReg   <= 1'b1;
               busyReg <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx   = txReg;
   assign bus.busy = busyReg;
   assign bus.done = doneReg;

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx at 16 clocks per bit. Follows the
// STATUS_CHECKSUM_EN build option to expect a 4- or 5-byte packet.
module tb_uart_status_tx;

   localparam int CPB = 16;
   localparam int BIT_CYC = CPB;
   localparam int BYTE_CYC = 10 * CPB;
`ifdef STATUS_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int PKT_CYC = NB * BYTE_CYC;
   localparam int LEN = 1000;

   logic clk;
   logic reset;
   int   nChecks;
   int   nFail;
   logic txSamp [0:LEN-1];

   uart_status_tx_if bus ();

   uart_status_tx #(
      .CLK_FREQ(16),
      .BAUD    (1),
      .HEADER  (8'hA5)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when observed differs from expected.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Send one packet and check it. kind: 0 plain, 1 send with p_hp=00 at
   // cycle 'at', 2 reset at cycle 'at', 3 send pulse at cycle 'at'.
   task automatic runPacket(input logic [7:0] hp, input logic [7:0] mh,
                            input logic [7:0] ms, input int kind,
                            input int at, input string name);
      int         busyCnt;
      int         doneCnt;
      int         doneAt;
      logic       prevBusy;
      logic [7:0] expB [0:4];
      logic [7:0] got;
      busyCnt  = 0;
      doneCnt  = 0;
      doneAt   = -1;
      prevBusy = 1'b1;
      expB[0] = 8'hA5;
      expB[1] = hp;
      expB[2] = mh;
      expB[3] = ms;
      expB[4] = 8'((16'(hp) + 16'(mh) + 16'(ms)) & 16'h00FF);

      @(negedge clk);
      bus.p_hp    = hp;
      bus.mon_hp  = mh;
      bus.m_state = ms;
      bus.send    = 1'b1;
      check({name, ".txIdleBefore"}, 32'(bus.tx), 32'd1);
      @(negedge clk);
      bus.send = 1'b0;
      check({name, ".txLowNext"}, 32'(bus.tx), 32'd0);
      check({name, ".busyRise"}, 32'(bus.busy), 32'd1);

      for (int t = 0; t < LEN; t++) begin
         if (t > 0) @(negedge clk);
         txSamp[t] = bus.tx;
         if (bus.busy) busyCnt++;
         if (bus.done) begin
            doneCnt++;
            if (doneAt < 0) doneAt = t;
            check({name, ".doneOnBusyFall"}, {30'd0, prevBusy, bus.busy}, 32'd2);
         end
         prevBusy = bus.busy;
         if ((kind == 1) && (t == at)) begin
            bus.send = 1'b1;
            bus.p_hp = 8'h00;
         end
         if ((kind == 3) && (t == at)) bus.send = 1'b1;
         if (((kind == 1) || (kind == 3)) && (t == at + 1)) bus.send = 1'b0;
         if ((kind == 2) && (t == at)) reset = 1'b1;
         if ((kind == 2) && (t == at + 1)) begin
            check({name, ".rstTx"}, 32'(bus.tx), 32'd1);
            check({name, ".rstBusy"}, 32'(bus.busy), 32'd0);
            check({name, ".rstDone"}, 32'(bus.done), 32'd0);
            reset = 1'b0;
            return;
         end
      end

      check({name, ".busyCycles"}, 32'(busyCnt), 32'(PKT_CYC));
      check({name, ".doneCount"}, 32'(doneCnt), 32'd1);
      check({name, ".doneCycle"}, 32'(doneAt), 32'(PKT_CYC));
      check({name, ".txIdleAfter"}, 32'(txSamp[LEN-1]), 32'd1);
      for (int b = 0; b < NB; b++) begin
         check($sformatf("%s.start%0d", name, b), 32'(txSamp[b*BYTE_CYC + BIT_CYC/2]), 32'd0);
         got = 8'h00;
         for (int k = 0; k < 8; k++)
            got[k] = txSamp[b*BYTE_CYC + (k+1)*BIT_CYC + BIT_CYC/2];
         check($sformatf("%s.byte%0d", name, b), 32'(got), 32'(expB[b]));
         check($sformatf("%s.stop%0d", name, b), 32'(txSamp[b*BYTE_CYC + 9*BIT_CYC + BIT_CYC/2]), 32'd1);
      end
   endtask

   initial begin
      nChecks     = 0;
      nFail       = 0;
      reset       = 1'b1;
      bus.send    = 1'b0;
      bus.p_hp    = 8'h00;
      bus.mon_hp  = 8'h00;
      bus.m_state = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.tx", 32'(bus.tx), 32'd1);
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.done", 32'(bus.done), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle.tx", 32'(bus.tx), 32'd1);
         check("idle.busy", 32'(bus.busy), 32'd0);
         check("idle.done", 32'(bus.done), 32'd0);
      end

      runPacket(8'h64, 8'h32, 8'h03, 0, 0, "single");
      runPacket(8'hFF, 8'hFF, 8'h03, 0, 0, "wrap");
      runPacket(8'h64, 8'h32, 8'h03, 1, 200, "ignBusy");
      runPacket(8'h64, 8'h32, 8'h03, 3, PKT_CYC, "ignDone");
      runPacket(8'h64, 8'h32, 8'h03, 2, 300, "rstMid");
      runPacket(8'h64, 8'h32, 8'h03, 0, 0, "afterRst");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/uart_status_tx.md
Name: uart_status_tx

Overview:
- UART transmitter that streams a fixed game-status packet (player HP, monster HP, machine state) out of the board to the host PC on the serial TX line.
- Outbound counterpart to the keyboard receive path: the receiver brings host keys in, this block sends game state back out.
- Sits beside the game machine at top level; on each send pulse it latches the status bytes and drives the serial TX pin as 8N1, LSB first.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 10416 at the defaults).
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- send  in  1  request to transmit one packet; sampled every cycle.
- p_hp  in  8  player HP; latched when the request is accepted.
- mon_hp  in  8  monster HP; latched when the request is accepted.
- m_state  in  8  machine state byte; latched when the request is accepted.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a packet is in flight.
- done  out  1  one-cycle pulse when the packet completes.

Behaviour:
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If send=1, then on that edge:
  - latch p_hp, mon_hp and m_state;
  - set byte index to 0 and busy=1;
  - go to START.
- tx goes low on the cycle after send is sampled (1-cycle latency).
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=current_byte[bit_idx] for CLKS_PER_BIT cycles per bit, bit 0 first. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if more bytes remain, increment byte index and go straight to START (no idle gap between bytes);
  - otherwise go to IDLE, drop busy, and pulse done=1 for exactly one cycle.
- Packet byte order: HEADER, p_hp, mon_hp, m_state, checksum.
- Checksum = (p_hp + mon_hp + m_state) mod 256, computed from the latched values with 8-bit wrap.
- send while busy=1 is ignored; it is neither queued nor allowed to alter the latched data.
- send in the same cycle that done pulses is also ignored. A new packet can only start from IDLE, i.e. one cycle after done.
- Input changes after latching have no effect on the packet in flight.
- Reset asserted mid-packet: next edge forces tx=1, busy=0, done=0 and IDLE. The partial frame is abandoned and not resumed.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. It is cleared on every state entry, so each bit lasts exactly CLKS_PER_BIT cycles.
- Packet length: 5 bytes × 10 bits × CLKS_PER_BIT cycles.

Optional Feature:
- Macro: STATUS_CHECKSUM_EN.
- Defined: the packet is 5 bytes and ends with the checksum byte as described above.
- Undefined: the packet is 4 bytes (HEADER, p_hp, mon_hp, m_state) and the checksum logic is removed. done follows the stop bit of m_state; all other timing is unchanged.

Test Plan:
- Reset then idle: hold reset 3 cycles, send=0 for 50 cycles -> tx=1, busy=0, done=0 throughout.
- Single packet (CLK_FREQ=16, BAUD=1, so 16 cycles per bit, macro defined), with p_hp=8'h64, mon_hp=8'h32, m_state=8'h03, send pulsed 1 cycle:
  - tx low 1 cycle later;
  - decoded bytes A5,64,32,03,99;
  - busy high for 800 cycles;
  - done pulses once, in the cycle busy falls.
- Checksum wrap: p_hp=FF, mon_hp=FF, m_state=03 -> checksum byte 01.
- Ignore while busy: during the packet above, pulse send with p_hp=00 at cycle 200 -> packet unchanged, no second packet, exactly one done pulse.
- Reset mid-packet: assert reset at cycle 300 of a packet -> next cycle tx=1 and busy=0; a fresh send then produces a complete, correct packet.
- Macro undefined, same stimulus as the single-packet test -> 4 bytes A5,64,32,03; busy high for 640 cycles; one done pulse.
